// File: rtl/joystick_dir_filter.sv
// Joystick direction filter: steers the ADC between X and Y, classifies samples
// with hysteresis, debounces per axis and emits single-cycle move pulses.
module joystick_dir_filter #(
  parameter int HI_THRESH      = 3072,
  parameter int LO_THRESH      = 1024,
  parameter int HYST           = 256,
  parameter int SETTLE_SAMPLES = 4,
  parameter int HOLD_CYCLES    = 781250,
  parameter int REPEAT_CYCLES  = 312500,
  parameter int X_CHAN         = 0,
  parameter int Y_CHAN         = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [2:0]  sample_chan,
  input  logic [11:0] sample_data,
  output logic [2:0]  chan_req,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right
);

  typedef enum logic [1:0] {Z_CEN, Z_POS, Z_NEG} zone_t;
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [12:0] HI   = 13'(HI_THRESH);
  localparam logic [12:0] LO   = 13'(LO_THRESH);
  localparam logic [12:0] HI_H = 13'(HI_THRESH - HYST);
  localparam logic [12:0] LO_H = 13'(LO_THRESH + HYST);
  localparam logic [3:0]  SETTLE = 4'(SETTLE_SAMPLES);
  localparam logic [2:0]  XC = 3'(X_CHAN);
  localparam logic [2:0]  YC = 3'(Y_CHAN);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  function automatic zone_t classify(input logic [11:0] data, input zone_t cur);
    logic [12:0] d;
    d = {1'b0, data};
    classify = Z_CEN;
    case (cur)
      Z_POS: begin
        if (d > HI_H) classify = Z_POS;
        else if (d < LO) classify = Z_NEG;
      end
      Z_NEG: begin
        if (d < LO_H) classify = Z_NEG;
        else if (d > HI) classify = Z_POS;
      end
      default: begin
        if (d > HI) classify = Z_POS;
        else if (d < LO) classify = Z_NEG;
      end
    endcase
  endfunction

  // index 0 = X axis, 1 = Y axis
  zone_t         comm [2];
  zone_t         comm_n [2];
  zone_t         prev [2];
  zone_t         prev_n [2];
  logic [3:0]    cnt [2];
  logic [3:0]    cnt_n [2];
  state_t        st [2];
  state_t        st_n [2];
  zone_t         dir [2];
  zone_t         dir_n [2];
  zone_t         req [2];
  logic [TW-1:0] tmr [2];
  logic [TW-1:0] tmr_n [2];
  zone_t         pend;
  zone_t         pend_n;
  zone_t         raw;
  logic [3:0]    mv_n;
  logic          accept;
  logic          ax;

  assign accept = sample_valid && (sample_chan == chan_req);
  assign ax     = (chan_req != XC);

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      comm_n[a] = comm[a];
      prev_n[a] = prev[a];
      cnt_n[a]  = cnt[a];
    end
    raw = classify(sample_data, comm[ax]);
    if (accept) begin
      prev_n[ax] = raw;
      if (raw == prev[ax])
        cnt_n[ax] = (cnt[ax] >= SETTLE) ? SETTLE : cnt[ax] + 4'd1;
      else
        cnt_n[ax] = 4'd1;
      if (cnt_n[ax] == SETTLE) comm_n[ax] = raw;
    end
  end

  // FSMs react to the zone committed this cycle, giving one-cycle pulse latency
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      st_n[a]  = st[a];
      dir_n[a] = dir[a];
      tmr_n[a] = tmr[a];
      req[a]   = Z_CEN;
      if (!enable || comm_n[a] == Z_CEN) begin
        st_n[a] = S_IDLE;
        tmr_n[a] = '0;
      end else if (st[a] == S_IDLE || comm_n[a] != dir[a]) begin
        req[a]   = comm_n[a];
        dir_n[a] = comm_n[a];
        st_n[a]  = S_DELAY;
        tmr_n[a] = '0;
      end else if (st[a] == S_DELAY && tmr[a] == HOLD_LAST) begin
        req[a]   = dir[a];
        st_n[a]  = S_REPEAT;
        tmr_n[a] = '0;
      end else if (st[a] == S_REPEAT && tmr[a] == REP_LAST) begin
        req[a]   = dir[a];
        tmr_n[a] = '0;
      end else begin
        tmr_n[a] = tmr[a] + TW'(1);
      end
    end
  end

  // mv_n = {up, down, left, right}; X wins, Y waits one cycle in pend
  always_comb begin
    mv_n   = 4'b0000;
    pend_n = pend;
    if (!enable) begin
      pend_n = Z_CEN;
    end else if (req[0] != Z_CEN) begin
      mv_n = (req[0] == Z_POS) ? 4'b0001 : 4'b0010;
      if (req[1] != Z_CEN) pend_n = req[1];
    end else if (req[1] != Z_CEN) begin
      mv_n   = (req[1] == Z_POS) ? 4'b1000 : 4'b0100;
      pend_n = Z_CEN;
    end else if (pend != Z_CEN) begin
      mv_n   = (pend == Z_POS) ? 4'b1000 : 4'b0100;
      pend_n = Z_CEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chan_req <= XC;
      pend     <= Z_CEN;
      {up, down, left, right} <= 4'b0000;
      for (int a = 0; a < 2; a++) begin
        comm[a] <= Z_CEN;
        prev[a] <= Z_CEN;
        cnt[a]  <= '0;
        st[a]   <= S_IDLE;
        dir[a]  <= Z_CEN;
        tmr[a]  <= '0;
      end
    end else begin
      if (accept) chan_req <= (chan_req == XC) ? YC : XC;
      pend <= pend_n;
      {up, down, left, right} <= mv_n;
      for (int a = 0; a < 2; a++) begin
        comm[a] <= comm_n[a];
        prev[a] <= prev_n[a];
        cnt[a]  <= cnt_n[a];
        st[a]   <= st_n[a];
        dir[a]  <= dir_n[a];
        tmr[a]  <= tmr_n[a];
      end
    end
  end

endmodule

// File: tb/tb_joystick_dir_filter.sv
// Directed bench for joystick_dir_filter with short settle/hold/repeat times.
module tb_joystick_dir_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        sample_valid = 1'b0;
  logic [2:0]  sample_chan = 3'd0;
  logic [11:0] sample_data = 12'd0;
  logic [2:0]  chan_req;
  logic        up, down, left, right;
  logic [3:0]  mv;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int nr = 0, nl = 0, nu = 0, nd = 0, multi = 0;
  int lq[$];

  assign mv = {up, down, left, right};

  joystick_dir_filter #(
    .SETTLE_SAMPLES(2),
    .HOLD_CYCLES(100),
    .REPEAT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample_chan(sample_chan),
    .sample_data(sample_data),
    .chan_req(chan_req),
    .up(up),
    .down(down),
    .left(left),
    .right(right)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (right) nr++;
    if (left) begin
      nl++;
      lq.push_back(cyc);
    end
    if (up) nu++;
    if (down) nd++;
    if ($countones(mv) > 1) multi++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] ch, input logic [11:0] d);
    sample_valid = 1'b1;
    sample_chan  = ch;
    sample_data  = d;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  function automatic int npulses();
    return nr + nl + nu + nd;
  endfunction

  int snap, t0, t1, li0;
  int rep_off [6] = '{0, 100, 120, 140, 160, 180};

  initial begin
    tick(3);
    reset = 1'b0;
    chk("reset_chan", chan_req, 0);
    chk("reset_out", mv, 0);

    send(3'd0, 12'd2048);
    chk("steer1", chan_req, 1);
    send(3'd1, 12'd2048);
    chk("steer2", chan_req, 0);
    send(3'd0, 12'd2048);
    chk("steer3", chan_req, 1);
    send(3'd5, 12'd2048);
    chk("steer_other", chan_req, 1);
    send(3'd1, 12'd2048);

    snap = nr;
    send(3'd0, 12'd4000);
    chk("move_unsettled", mv, 0);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd4000);
    chk("move_right", mv, 4'b0001);
    tick(1);
    chk("move_single", mv, 0);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd2048);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd2048);
    tick(5);
    chk("move_count", nr - snap, 1);

    send(3'd1, 12'd2048);
    send(3'd0, 12'd100);
    send(3'd1, 12'd2048);
    li0 = lq.size();
    send(3'd0, 12'd100);
    t0 = cyc;
    chk("rep_first", mv, 4'b0010);
    tick(190);
    chk("rep_count", lq.size() - li0, 6);
    for (int k = 0; k < 6; k++)
      if (li0 + k < lq.size())
        chk($sformatf("rep_time%0d", k), lq[li0 + k] - t0, rep_off[k]);

    send(3'd1, 12'd2048);
    send(3'd0, 12'd4000);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd4000);
    t1 = cyc;
    chk("flip_right", mv, 4'b0001);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd2900);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd2900);
    tick(t1 + 100 - cyc);
    chk("hyst_hold_pos", mv, 4'b0001);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd2700);
    send(3'd1, 12'd2048);
    snap = npulses();
    send(3'd0, 12'd2700);
    tick(40);
    chk("hyst_exit_centre", npulses() - snap, 0);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd4000);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd2048);
    send(3'd1, 12'd2048);
    send(3'd0, 12'd4000);
    send(3'd1, 12'd2048);
    tick(5);
    chk("debounce_alt", npulses() - snap, 0);
    send(3'd0, 12'd2048);
    send(3'd1, 12'd2048);

    enable = 1'b0;
    snap = npulses();
    send(3'd0, 12'd4000);
    send(3'd1, 12'd4000);
    send(3'd0, 12'd4000);
    send(3'd1, 12'd4000);
    tick(3);
    chk("disabled_quiet", npulses() - snap, 0);
    enable = 1'b1;
    tick(1);
    chk("simul_x", mv, 4'b0001);
    tick(1);
    chk("simul_y", mv, 4'b1000);
    tick(1);
    chk("simul_done", mv, 0);

    enable = 1'b0;
    snap = npulses();
    tick(30);
    chk("disable_hold", npulses() - snap, 0);
    enable = 1'b1;
    tick(1);
    chk("enable_rise", mv, 4'b0001);
    tick(110);
    send(3'd0, 12'd4000);
    chk("pre_reset_chan", chan_req, 1);
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_chan  = 3'd1;
    sample_data  = 12'd100;
    tick(1);
    sample_valid = 1'b0;
    chk("reset_mid_out", mv, 0);
    chk("reset_mid_chan", chan_req, 0);
    reset = 1'b0;
    snap = npulses();
    tick(150);
    chk("reset_no_pulses", npulses() - snap, 0);
    chk("onehot", multi, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
